// File: rtl/tensor_core_sequencer.sv
// Instruction sequencer for a tensor core: decodes register-file moves, immediates,
// tensor operations and matrix bursts, and drives the register file and tensor core.
module tensor_core_sequencer #(
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned MATRIX_DIM = 3,
    parameter int unsigned OP_LATENCY = 4
) (
    input  logic                 clock_in,
    input  logic                 reset_n_in,
    input  logic [15:0]          instruction_in,
    input  logic                 instruction_valid_in,
    output logic                 instruction_ready_out,
    input  logic [BUS_WIDTH-1:0] burst_data_in,
    input  logic                 burst_data_valid_in,
    output logic                 burst_data_ready_out,
    output logic [4:0]           rf_read_addr_out,
    input  logic [BUS_WIDTH-1:0] rf_read_data_in,
    output logic                 rf_write_en_out,
    output logic [4:0]           rf_write_addr_out,
    output logic [BUS_WIDTH-1:0] rf_write_data_out,
    output logic                 rf_bulk_write_en_out,
    output logic                 rf_reset_out,
    output logic                 tc_start_out,
    output logic [2:0]           tc_op_select_out,
    output logic [BUS_WIDTH-1:0] cpu_output_out,
    output logic                 cpu_output_valid_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned TMR_W    = 4;
    localparam int unsigned MAT_SIZE = MATRIX_DIM * MATRIX_DIM;

    localparam logic [1:0] OPC_GENERIC = 2'b00;
    localparam logic [1:0] OPC_LOADI   = 2'b01;
    localparam logic [1:0] OPC_OPERATE = 2'b10;
    localparam logic [1:0] OPC_BURST   = 2'b11;

    localparam logic [1:0] GEN_READ  = 2'b00;
    localparam logic [1:0] GEN_MOVE  = 2'b01;
    localparam logic [1:0] GEN_RESET = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPERATE,
        ST_WRITEBACK,
        ST_BURST_READ,
        ST_BURST_WRITE
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    burst_base;
    logic [IDX_W-1:0]    burst_last;
    logic [TMR_W-1:0]    timer;

    logic [1:0]          opcode;
    logic [1:0]          gen_sel;
    logic [1:0]          mat_sel;
    logic                burst_wr;
    logic [ADDR_W-1:0]   dest_addr;
    logic [ADDR_W-1:0]   src_addr;
    logic                gen_reset;
    logic                accept;
    logic [ADDR_W-1:0]   burst_addr;

    assign opcode     = instruction_in[1:0];
    assign gen_sel    = instruction_in[3:2];
    assign mat_sel    = instruction_in[4:3];
    assign burst_wr   = instruction_in[2];
    assign dest_addr  = instruction_in[15:11];
    assign src_addr   = instruction_in[10:6];
    assign gen_reset  = instruction_valid_in && (opcode == OPC_GENERIC) && (gen_sel == GEN_RESET);
    assign accept     = instruction_valid_in && (state == ST_IDLE);
    assign burst_addr = ADDR_W'(burst_base + idx);

    // State, burst index, operation timer and latched op select
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state            <= ST_IDLE;
            idx              <= '0;
            timer            <= '0;
            burst_base       <= '0;
            burst_last       <= '0;
            tc_op_select_out <= '0;
        end else if (gen_reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            timer <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && opcode == OPC_OPERATE) begin
                        tc_op_select_out <= instruction_in[4:2];
                        timer            <= '0;
                        state            <= ST_OPERATE;
                    end else if (accept && opcode == OPC_BURST && mat_sel != 2'b11) begin
                        burst_base <= (mat_sel == 2'b01) ? IDX_W'(MAT_SIZE) : '0;
                        burst_last <= (mat_sel == 2'b10) ? IDX_W'(2 * MAT_SIZE - 1)
                                                         : IDX_W'(MAT_SIZE - 1);
                        idx        <= '0;
                        // R/W bit set selects a burst write
                        state      <= burst_wr ? ST_BURST_WRITE : ST_BURST_READ;
                    end
                end
                ST_OPERATE: begin
                    if (timer == TMR_W'(OP_LATENCY - 1)) begin
                        timer <= '0;
                        state <= ST_WRITEBACK;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_WRITEBACK: state <= ST_IDLE;
                ST_BURST_READ: begin
                    if (idx == burst_last) begin
                        idx   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_BURST_WRITE: begin
                    if (burst_data_valid_in) begin
                        if (idx == burst_last) begin
                            idx   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output decode; everything is forced low while reset is held
    always_comb begin
        instruction_ready_out = 1'b0;
        burst_data_ready_out  = 1'b0;
        rf_read_addr_out      = '0;
        rf_write_en_out       = 1'b0;
        rf_write_addr_out     = '0;
        rf_write_data_out     = '0;
        rf_bulk_write_en_out  = 1'b0;
        rf_reset_out          = 1'b0;
        tc_start_out          = 1'b0;
        cpu_output_out        = '0;
        cpu_output_valid_out  = 1'b0;
        busy_out              = 1'b0;
        done_out              = 1'b0;
        if (reset_n_in) begin
            instruction_ready_out = (state == ST_IDLE);
            busy_out              = (state != ST_IDLE);
            rf_reset_out          = gen_reset;
            case (state)
                ST_IDLE: begin
                    rf_read_addr_out = src_addr;
                    if (instruction_valid_in && opcode == OPC_GENERIC && gen_sel == GEN_READ) begin
                        cpu_output_out       = rf_read_data_in;
                        cpu_output_valid_out = 1'b1;
                    end
                    if (instruction_valid_in && opcode == OPC_GENERIC && gen_sel == GEN_MOVE) begin
                        rf_write_en_out   = 1'b1;
                        rf_write_addr_out = dest_addr;
                        rf_write_data_out = rf_read_data_in;
                    end
                    if (instruction_valid_in && opcode == OPC_LOADI) begin
                        rf_write_en_out   = 1'b1;
                        rf_write_addr_out = dest_addr;
                        rf_write_data_out = BUS_WIDTH'($signed(instruction_in[10:3]));
                    end
                end
                ST_OPERATE: tc_start_out = (timer == '0);
                ST_WRITEBACK: begin
                    rf_bulk_write_en_out = !gen_reset;
                    done_out             = !gen_reset;
                end
                ST_BURST_READ: begin
                    rf_read_addr_out     = burst_addr;
                    cpu_output_out       = rf_read_data_in;
                    cpu_output_valid_out = 1'b1;
                end
                ST_BURST_WRITE: begin
                    burst_data_ready_out = !gen_reset;
                    rf_write_en_out      = burst_data_valid_in && !gen_reset;
                    rf_write_addr_out    = burst_addr;
                    rf_write_data_out    = burst_data_in;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tensor_core_sequencer.md
TENSOR_CORE_SEQUENCER -- requirements
Module: tensor_core_sequencer

Interface
REQ-001 Parameter BUS_WIDTH, default 8, signed element width in bits.
REQ-002 Parameter MATRIX_DIM, default 3, matrix side N; legal range 2..4, so 2*N*N <= 32 registers.
REQ-003 Parameter OP_LATENCY, default 4, tensor-core compute cycles; legal range 1..15.
REQ-004 clock_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n_in  input  1  reset, asynchronous assertion, active-low.
REQ-006 instruction_in  input  16  instruction: opcode [1:0], generic opselect [3:2], operate opselect [4:2], burst matrix select [4:3], burst R/W [2], dest addr [15:11], src addr [10:6], immediate [10:3].
REQ-007 instruction_valid_in  input  1  instruction_in is valid this cycle.
REQ-008 instruction_ready_out  output  1  sequencer accepts an instruction this cycle.
REQ-009 burst_data_in  input  BUS_WIDTH  element for a burst write.
REQ-010 burst_data_valid_in  input  1  burst_data_in is valid.
REQ-011 burst_data_ready_out  output  1  burst element is consumed this cycle.
REQ-012 rf_read_addr_out  output  5  register-file read address.
REQ-013 rf_read_data_in  input  BUS_WIDTH  register-file read data, combinational from rf_read_addr_out.
REQ-014 rf_write_en_out / rf_write_addr_out / rf_write_data_out  output  1/5/BUS_WIDTH  single-register write port.
REQ-015 rf_bulk_write_en_out  output  1  commit tensor-core result into matrix 1.
REQ-016 rf_reset_out  output  1  clear register file and tensor core.
REQ-017 tc_start_out  output  1  tensor-core start pulse.
REQ-018 tc_op_select_out  output  3  operation select, held for the whole operation.
REQ-019 cpu_output_out  output  BUS_WIDTH  read data; zero whenever cpu_output_valid_out=0.
REQ-020 cpu_output_valid_out  output  1  cpu_output_out is valid.
REQ-021 busy_out  output  1  state is not IDLE.
REQ-022 done_out  output  1  one-cycle pulse on result commit.

Function
REQ-023 States are IDLE, OPERATE, WRITEBACK, BURST_READ and BURST_WRITE; instruction_ready_out = (state==IDLE).
REQ-024 An instruction is accepted on a rising edge with valid && ready; in non-IDLE states only GENERIC_RESET is honoured.
REQ-025 GENERIC_RESET (00/11) with valid=1 in any state: rf_reset_out=1 combinationally; next state IDLE; counters cleared; a running burst or operation is aborted with no bulk write.
REQ-026 GENERIC_READ (00/00) in IDLE: rf_read_addr_out=[10:6]; cpu_output_out=rf_read_data_in; cpu_output_valid_out=1, same cycle.
REQ-027 GENERIC_MOVE (00/01) in IDLE: read [10:6]; write rf_read_data_in to [15:11] that edge.
REQ-028 GENERIC_NOP and invalid cycles: no writes; state unchanged.
REQ-029 LOAD_IMMEDIATE (01) in IDLE: write [10:3] (truncated or sign-extended to BUS_WIDTH) to [15:11] that edge.
REQ-030 OPERATE (10), on accept: latch [4:2] into tc_op_select_out.
REQ-031 OPERATE state lasts exactly OP_LATENCY cycles; tc_start_out is high only in its first cycle.
REQ-032 WRITEBACK lasts 1 cycle with rf_bulk_write_en_out=1 and done_out=1, then IDLE.
REQ-033 OPERATE and WRITEBACK together hold busy for OP_LATENCY+1 cycles.
REQ-034 BURST (11), on accept: base is 0 for select 00, N*N for 01, 0 for 10; length is N*N for 00/01 and 2*N*N for 10; select 11 behaves as NOP.
REQ-035 BURST_READ: each cycle rf_read_addr_out = base+index; cpu_output_out=rf_read_data_in; cpu_output_valid_out=1; index increments.
REQ-036 BURST_READ: after the cycle with index=length-1, next state IDLE.
REQ-037 BURST_WRITE: burst_data_ready_out=1; on edges with burst_data_valid_in=1, write burst_data_in to base+index and increment index.
REQ-038 BURST_WRITE: stall indefinitely while burst_data_valid_in=0; next state IDLE after the last element is written.
REQ-039 Index counter is 6 bits and never wraps; the last-element compare ends the burst exactly.
REQ-040 At most one rf write per cycle; rf_write_en_out is never asserted in OPERATE or WRITEBACK.

Reset
REQ-041 reset_n_in=0 forces state IDLE, index 0, timer 0, tc_op_select_out 0, independent of clock_in.
REQ-042 While reset_n_in=0, all outputs are 0 except instruction_ready_out, which is 1 once reset_n_in releases.
REQ-043 The first instruction is accepted on the first rising edge after reset_n_in deasserts.

Verification (N=3, BUS_WIDTH=8, OP_LATENCY=4)
REQ-044 LOAD_IMMEDIATE dest 5, imm 0x7F, then GENERIC_READ src 5 -> cpu_output_out=0x7F, valid=1 on the read cycle.
REQ-045 OPERATE opsel 3'b010 -> tc_start_out high 1 cycle; busy 5 cycles; rf_bulk_write_en_out and done_out high in cycle 5 only.
REQ-046 BURST write, select 01, data 1..9 with valid low on 2 cycles -> registers 9..17 hold 1..9 after 11 cycles; busy then drops.
REQ-047 BURST read, select 10 -> 18 consecutive valid outputs, addresses 0..17; ready returns on cycle 19.
REQ-048 GENERIC_RESET in OPERATE cycle 2 -> no bulk write; rf_reset_out=1; IDLE next cycle; done_out stays 0.
REQ-049 Assert reset_n_in mid-burst-write between edges -> outputs zero immediately; no further rf writes.
